// File: rtl/umbral_fsm_n.sv
// Flow-control and status FSM for NUM_FIFO monitored FIFOs: latches thresholds during INIT,
// registers almost-full/almost-empty flags, drives the upstream pause and tracks sticky overflows.
module umbral_fsm_n #(
    parameter int NUM_FIFO = 5,
    parameter int CW       = 5,
    parameter int TW       = 4,
    parameter int HYST     = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic [NUM_FIFO*TW-1:0]   umbral_high,
    input  logic [NUM_FIFO*TW-1:0]   umbral_low,
    input  logic [NUM_FIFO*CW-1:0]   fifo_count,
    input  logic [NUM_FIFO-1:0]      fifo_empty,
    input  logic [NUM_FIFO-1:0]      fifo_full,
    input  logic [NUM_FIFO-1:0]      fifo_push,
    output logic [NUM_FIFO-1:0]      almost_full,
    output logic [NUM_FIFO-1:0]      almost_empty,
    output logic                     pause,
    output logic [NUM_FIFO-1:0]      error_full,
    output logic                     idle_out,
    output logic                     active_out,
    output logic                     error_out,
    output logic [2:0]               state
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    if (TW > CW) begin : g_bad_width
        $error("umbral_fsm_n: TW must not exceed CW");
    end

    state_e                   state_q, state_d;
    logic [NUM_FIFO*TW-1:0]   high_q, high_d;
    logic [NUM_FIFO*TW-1:0]   low_q, low_d;
    logic [NUM_FIFO-1:0]      af_q, af_d;
    logic [NUM_FIFO-1:0]      ae_q, ae_d;
    logic [NUM_FIFO-1:0]      err_q, err_d;
    logic                     pause_q, pause_d;

    logic [NUM_FIFO-1:0]      cmp_af;
    logic [NUM_FIFO-1:0]      cmp_ae;
    logic [NUM_FIFO-1:0]      ovf_vec;
    logic                     monitoring;
    logic                     overflow;

    // Thresholds are zero-extended to the count width; a zero high threshold disables almost_full.
    for (genvar i = 0; i < NUM_FIFO; i++) begin : g_cmp
        assign cmp_af[i] = (high_q[i*TW +: TW] != '0) &&
                           (fifo_count[i*CW +: CW] >= CW'(high_q[i*TW +: TW]));
        assign cmp_ae[i] = (fifo_count[i*CW +: CW] <= CW'(low_q[i*TW +: TW]));
    end

    assign ovf_vec    = fifo_push & fifo_full;
    assign monitoring = (state_q == ST_IDLE) || (state_q == ST_ACTIVE) || (state_q == ST_ERROR);
    assign overflow   = monitoring && (|ovf_vec);

    always_comb begin
        // NOTE: every target gets a default first so no path through the case can infer a latch.
        state_d = state_q;
        high_d  = high_q;
        low_d   = low_q;
        af_d    = '0;
        ae_d    = '0;
        pause_d = 1'b0;
        err_d   = err_q;

        if (monitoring) begin
            af_d  = cmp_af;
            ae_d  = cmp_ae;
            err_d = err_q | ovf_vec;
            if (HYST == 0) begin
                pause_d = |cmp_af;
            end else if (|cmp_af) begin
                pause_d = 1'b1;
            end else if (&cmp_ae) begin
                pause_d = 1'b0;
            end else begin
                pause_d = pause_q;
            end
        end

        unique case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                high_d = umbral_high;
                low_d  = umbral_low;
                if (!init) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (overflow)           state_d = ST_ERROR;
                else if (init)          state_d = ST_INIT;
                else if (!(&fifo_empty)) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (overflow)           state_d = ST_ERROR;
                else if (init)          state_d = ST_INIT;
                else if (&fifo_empty)   state_d = ST_IDLE;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET;
        endcase
    end

    // NOTE: reset clears thresholds and sticky errors as well; nothing survives a reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
            high_q  <= '0;
            low_q   <= '0;
            af_q    <= '0;
            ae_q    <= '0;
            err_q   <= '0;
            pause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            high_q  <= high_d;
            low_q   <= low_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            err_q   <= err_d;
            pause_q <= pause_d;
        end
    end

    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign pause        = pause_q;
    assign error_full   = err_q;
    assign state        = state_q;
    assign idle_out     = (state_q == ST_IDLE);
    assign active_out   = (state_q == ST_ACTIVE);
    assign error_out    = (state_q == ST_ERROR);

endmodule

// File: tb/tb_umbral_fsm_n.sv
// Directed bench for umbral_fsm_n: a HYST=1 and a HYST=0 instance share stimulus;
// a vector table covers the main flow, hand sequences cover overflow, re-init and reset.
module tb_umbral_fsm_n;

    localparam int N  = 5;
    localparam int CW = 5;
    localparam int TW = 4;

    typedef struct {
        logic          rst;
        logic          init;
        logic [N*TW-1:0] high;
        logic [N*TW-1:0] low;
        logic [N*CW-1:0] cnt;
        logic [N-1:0]  empty;
        logic [N-1:0]  full;
        logic [N-1:0]  push;
        logic [2:0]    exp_st;
        logic [N-1:0]  exp_af;
        logic [N-1:0]  exp_ae;
        logic          exp_p1;
        logic          exp_p0;
        logic [N-1:0]  exp_ef;
    } vec_t;

    logic            clk;
    logic            reset, init;
    logic [N*TW-1:0] umbral_high, umbral_low;
    logic [N*CW-1:0] fifo_count;
    logic [N-1:0]    fifo_empty, fifo_full, fifo_push;

    logic [N-1:0] af1, ae1, ef1, af0, ae0, ef0;
    logic         p1, p0, idle1, act1, err1, idle0, act0, err0;
    logic [2:0]   st1, st0;

    int checks = 0;
    int errors = 0;

    umbral_fsm_n #(.NUM_FIFO(N), .CW(CW), .TW(TW), .HYST(1)) dut_h1 (
        .clk(clk), .reset(reset), .init(init),
        .umbral_high(umbral_high), .umbral_low(umbral_low), .fifo_count(fifo_count),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_push(fifo_push),
        .almost_full(af1), .almost_empty(ae1), .pause(p1), .error_full(ef1),
        .idle_out(idle1), .active_out(act1), .error_out(err1), .state(st1)
    );

    umbral_fsm_n #(.NUM_FIFO(N), .CW(CW), .TW(TW), .HYST(0)) dut_h0 (
        .clk(clk), .reset(reset), .init(init),
        .umbral_high(umbral_high), .umbral_low(umbral_low), .fifo_count(fifo_count),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_push(fifo_push),
        .almost_full(af0), .almost_empty(ae0), .pause(p0), .error_full(ef0),
        .idle_out(idle0), .active_out(act0), .error_out(err0), .state(st0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*CW-1:0] pk(input int c4, input int c3, input int c2,
                                           input int c1, input int c0);
        return {5'(c4), 5'(c3), 5'(c2), 5'(c1), 5'(c0)};
    endfunction

    function automatic vec_t mk(input logic rst, input logic ini, input logic [N*CW-1:0] cnt,
                                input logic [N-1:0] emp, input logic [N-1:0] ful,
                                input logic [N-1:0] psh, input logic [2:0] st,
                                input logic [N-1:0] af, input logic [N-1:0] ae,
                                input logic ph1, input logic ph0, input logic [N-1:0] ef);
        vec_t v;
        v.rst = rst;  v.init = ini;  v.high = 20'h33333;  v.low = 20'h11111;
        v.cnt = cnt;  v.empty = emp; v.full = ful;        v.push = psh;
        v.exp_st = st; v.exp_af = af; v.exp_ae = ae;
        v.exp_p1 = ph1; v.exp_p0 = ph0; v.exp_ef = ef;
        return v;
    endfunction

    task automatic apply(input string tag, input vec_t v);
        reset = v.rst;  init = v.init;  umbral_high = v.high;  umbral_low = v.low;
        fifo_count = v.cnt;  fifo_empty = v.empty;  fifo_full = v.full;  fifo_push = v.push;
        @(posedge clk);
        #1;
        check({tag, " state"},        32'(st1), 32'(v.exp_st));
        check({tag, " status"},       32'({err1, act1, idle1}),
              32'({v.exp_st == 3'd4, v.exp_st == 3'd3, v.exp_st == 3'd2}));
        check({tag, " almost_full"},  32'(af1), 32'(v.exp_af));
        check({tag, " almost_empty"}, 32'(ae1), 32'(v.exp_ae));
        check({tag, " pause_hyst1"},  32'(p1),  32'(v.exp_p1));
        check({tag, " pause_hyst0"},  32'(p0),  32'(v.exp_p0));
        check({tag, " error_full"},   32'(ef1), 32'(v.exp_ef));
        check({tag, " state_hyst0"},  32'(st0), 32'(v.exp_st));
    endtask

    vec_t tbl[13];
    vec_t v;

    initial begin
        //              rst ini counts            empty     full      push      st  af        ae        p1 p0 ef
        tbl[0]  = mk(1, 0, pk(0,0,0,0,0),  5'b11111, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 5'b00000);
        tbl[1]  = mk(0, 1, pk(0,0,0,0,0),  5'b11111, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 5'b00000);
        tbl[2]  = mk(0, 1, pk(0,0,0,0,0),  5'b11111, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 5'b00000);
        tbl[3]  = mk(0, 0, pk(0,0,0,0,0),  5'b11111, 5'b00000, 5'b00000, 2, 5'b00000, 5'b00000, 0, 0, 5'b00000);
        tbl[4]  = mk(0, 0, pk(0,0,0,0,0),  5'b11111, 5'b00000, 5'b00000, 2, 5'b00000, 5'b11111, 0, 0, 5'b00000);
        tbl[5]  = mk(0, 0, pk(0,2,0,0,0),  5'b10111, 5'b00000, 5'b00000, 3, 5'b00000, 5'b10111, 0, 0, 5'b00000);
        tbl[6]  = mk(0, 0, pk(0,0,0,0,0),  5'b11111, 5'b00000, 5'b00000, 2, 5'b00000, 5'b11111, 0, 0, 5'b00000);
        tbl[7]  = mk(0, 0, pk(0,0,0,0,2),  5'b11110, 5'b00000, 5'b00000, 3, 5'b00000, 5'b11110, 0, 0, 5'b00000);
        tbl[8]  = mk(0, 0, pk(0,0,0,0,3),  5'b11110, 5'b00000, 5'b00000, 3, 5'b00001, 5'b11110, 1, 1, 5'b00000);
        tbl[9]  = mk(0, 0, pk(0,0,0,0,2),  5'b11110, 5'b00000, 5'b00000, 3, 5'b00000, 5'b11110, 1, 0, 5'b00000);
        tbl[10] = mk(0, 0, pk(0,0,0,0,1),  5'b11110, 5'b00000, 5'b00000, 3, 5'b00000, 5'b11111, 0, 0, 5'b00000);
        tbl[11] = mk(0, 0, pk(0,0,0,0,0),  5'b11111, 5'b00000, 5'b00000, 2, 5'b00000, 5'b11111, 0, 0, 5'b00000);
        tbl[12] = mk(0, 0, pk(1,0,0,0,0),  5'b01111, 5'b00000, 5'b00000, 3, 5'b00000, 5'b11111, 0, 0, 5'b00000);

        for (int i = 0; i < 13; i++) begin
            apply($sformatf("row%0d", i), tbl[i]);
        end

        // Overflow on FIFO 4 while ACTIVE.
        v = mk(0, 0, pk(1,0,0,0,0), 5'b01111, 5'b10000, 5'b10000, 4, 5'b00000, 5'b11111, 0, 0, 5'b10000);
        apply("ovf", v);
        // ERROR ignores init.
        v = mk(0, 1, pk(1,0,0,0,0), 5'b01111, 5'b00000, 5'b00000, 4, 5'b00000, 5'b11111, 0, 0, 5'b10000);
        apply("err_init", v);
        // Flags and pause keep tracking counts while in ERROR.
        v = mk(0, 1, pk(1,0,0,0,31), 5'b01110, 5'b00000, 5'b00000, 4, 5'b00001, 5'b11110, 1, 1, 5'b10000);
        apply("err_flags", v);
        // Reset clears everything including sticky errors.
        v = mk(1, 0, pk(0,0,0,0,0), 5'b11111, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 5'b00000);
        apply("rst2", v);

        // Re-init with high0 = 0: almost_full[0] stays low even at count 31.
        v = mk(0, 1, pk(0,0,0,0,0), 5'b11111, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 5'b00000);
        v.high = 20'h33330;
        apply("reinit_a", v);
        apply("reinit_b", v);
        v = mk(0, 0, pk(0,0,0,0,0), 5'b11111, 5'b00000, 5'b00000, 2, 5'b00000, 5'b00000, 0, 0, 5'b00000);
        v.high = 20'h33330;
        apply("reinit_idle", v);
        v = mk(0, 0, pk(0,0,0,5,31), 5'b11110, 5'b00000, 5'b00000, 3, 5'b00010, 5'b11100, 1, 1, 5'b00000);
        v.high = 20'h55550;
        apply("high0_zero", v);
        // Simultaneous init and overflow in ACTIVE: overflow wins.
        v = mk(0, 1, pk(0,0,0,5,31), 5'b11110, 5'b00010, 5'b00010, 4, 5'b00010, 5'b11100, 1, 1, 5'b00010);
        apply("init_vs_ovf", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
